// File: rtl/term_pkg.sv
// Shared definitions for the terminal transmit path: serializer state
// encoding, ASCII control characters and the default baud divisor.
package term_pkg;

  // Serializer frame phase.
  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;

  // 100 MHz system clock / 115200 baud.
  localparam int CLKS_PER_BIT_115200 = 868;

endpackage : term_pkg

// File: rtl/term_tx_fifo.sv
// Synchronous first-word-fall-through FIFO. dout always shows the head
// entry so the serializer can load and pop in the same cycle. Pushes while
// full and pops while empty are ignored.
module term_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage array written at the write pointer.
  // NOTE: the data array has no reset; only pointers and count define
  // validity, and leaving it unreset lets it map onto plain RAM/LUT storage.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule : term_tx_fifo

// File: rtl/term_tx.sv
// Terminal transmit engine: buffers printer bytes in a FIFO and serializes
// them as 8N1 UART frames on tx (idle high, LSB first). Frames leave the
// FIFO back-to-back with no idle gap while data is queued.
// Optional build macro TERM_TX_CRLF_EN: expand each LF into CR followed by LF.
module term_tx
  import term_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       char_valid,
  input  logic [7:0] char_data,
  output logic       char_ready,
  output logic       tx,
  output logic       busy,
  output logic       overflow
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  // FIFO interface
  logic             fifo_pop;
  logic [7:0]       fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  // Serializer state
  tx_state_t        state_q, state_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       bit_q, bit_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic             tx_q, tx_d;
  logic             load;
  logic             baud_last;

`ifdef TERM_TX_CRLF_EN
  logic             crlf_q, crlf_d;
`endif

  term_tx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (char_valid),
    .pop   (fifo_pop),
    .din   (char_data),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign char_ready = !fifo_full;
  assign busy       = (state_q != IDLE) || (fifo_count != '0);
  assign tx         = tx_q;
  assign baud_last  = (baud_q == BAUD_LAST);

  // Next-state, line level and FIFO pop for the frame serializer.
  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bit_d    = bit_q;
    baud_d   = baud_q;
    tx_d     = 1'b1;
    load     = 1'b0;
    fifo_pop = 1'b0;
`ifdef TERM_TX_CRLF_EN
    crlf_d   = crlf_q;
`endif

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          load = 1'b1;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      DATA: begin
        tx_d = shift_q[0];
        if (baud_last) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (baud_last) begin
          baud_d = '0;
          if (!fifo_empty) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Start a new frame from the FIFO head.
    if (load) begin
      state_d = START;
      baud_d  = '0;
`ifdef TERM_TX_CRLF_EN
      if (!crlf_q && (fifo_head == CHAR_LF)) begin
        // Send CR first; the LF stays at the head for the following frame.
        shift_d = CHAR_CR;
        crlf_d  = 1'b1;
      end else begin
        shift_d  = fifo_head;
        fifo_pop = 1'b1;
        crlf_d   = 1'b0;
      end
`else
      shift_d  = fifo_head;
      fifo_pop = 1'b1;
`endif
    end
  end

  // Serializer registers; tx is registered so the line is glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      baud_q  <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      baud_q  <= baud_d;
      tx_q    <= tx_d;
    end
  end

`ifdef TERM_TX_CRLF_EN
  // Remembers that the CR half of an LF expansion has been sent.
  always_ff @(posedge clk) begin
    if (rst) begin
      crlf_q <= 1'b0;
    end else begin
      crlf_q <= crlf_d;
    end
  end
`endif

  // Sticky flag for writes dropped because the FIFO was full.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (char_valid && fifo_full) begin
      overflow <= 1'b1;
    end
  end

endmodule : term_tx

// File: tb/tb_term_tx.sv
// Self-checking bench for term_tx. A UART line monitor decodes frames from
// tx; expected byte streams come from a queue model of accepted writes.
module tb_term_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 16;
  localparam int FRAME = 10 * CPB;

  typedef logic [7:0] byte_q_t[$];

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       char_valid = 1'b0;
  logic [7:0] char_data = 8'h00;
  logic       char_ready;
  logic       tx;
  logic       busy;
  logic       overflow;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  term_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .char_valid (char_valid),
    .char_data  (char_data),
    .char_ready (char_ready),
    .tx         (tx),
    .busy       (busy),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- line monitor ----------------
  byte_q_t  rx_q;
  int       start_q[$];
  int       frame_err = 0;
  bit       in_frame = 1'b0;
  int       pos = 0;
  logic [7:0] sh = 8'h00;

  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        in_frame = 1'b0;
      end else if (!in_frame) begin
        if (tx === 1'b0) begin
          in_frame = 1'b1;
          pos = 0;
          start_q.push_back(cyc);
        end
      end else begin
        pos++;
        if (pos == 2 && tx !== 1'b0) frame_err++;
        if (pos >= 6 && pos <= 34 && (pos % CPB) == 2) sh = {tx, sh[7:1]};
        if (pos == 38 && tx !== 1'b1) frame_err++;
        if (pos == FRAME - 1) begin
          rx_q.push_back(sh);
          in_frame = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic byte_q_t expand(byte_q_t in);
    byte_q_t out;
    foreach (in[i]) begin
`ifdef TERM_TX_CRLF_EN
      if (in[i] == 8'h0A) out.push_back(8'h0D);
`endif
      out.push_back(in[i]);
    end
    return out;
  endfunction

  // ---------------- bounded waits ----------------
  task automatic wait_frames(int n, int budget);
    int b = budget;
    while (rx_q.size() < n && b > 0) begin
      @(negedge clk); #1;
      b--;
    end
    checks++;
    if (rx_q.size() < n) begin
      errors++;
      $display("FAIL frame_wait got %0d frames required %0d", rx_q.size(), n);
    end
  endtask

  task automatic wait_idle(int budget);
    int b = budget;
    while (busy !== 1'b0 && b > 0) begin
      @(negedge clk); #1;
      b--;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_wait busy=%b required 0", busy);
    end
  endtask

  task automatic push_seq(byte_q_t bytes);
    foreach (bytes[i]) begin
      @(negedge clk); #1;
      char_valid = 1'b1;
      char_data  = bytes[i];
    end
    @(negedge clk); #1;
    char_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    repeat (50) @(negedge clk);
    #1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b required 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b required 0", busy); end
    checks++; if (char_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b required 1", char_ready); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b required 0", overflow); end
  endtask

  task automatic test_single;
    logic [7:0] d = 8'h55;
    logic exp;
    int base = rx_q.size();
    @(negedge clk); #1;
    char_valid = 1'b1;
    char_data  = d;
    @(posedge clk);                    // edge N
    @(negedge clk); #1;
    char_valid = 1'b0;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL single_tx_n got %b required 1", tx); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_n got %b required 1", busy); end
    @(negedge clk); #1;                // after edge N+1
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL single_tx_n1 got %b required 1", tx); end
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk); #1;              // after edge N+2+k
      if (k < CPB) exp = 1'b0;
      else if (k < 9 * CPB) exp = d[(k / CPB) - 1];
      else exp = 1'b1;
      checks++;
      if (tx !== exp) begin
        errors++;
        $display("FAIL single_bit cycle %0d got %b required %b", k, tx, exp);
      end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end got %b required 0", busy); end
    @(negedge clk); #1;
    checks++;
    if (rx_q.size() != base + 1 || rx_q[base] !== d) begin
      errors++;
      $display("FAIL single_decode frames=%0d required %0d", rx_q.size() - base, 1);
    end
  endtask

  task automatic test_back_to_back;
    byte_q_t msg = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
    byte_q_t exp = expand(msg);
    int base = rx_q.size();
    int sbase = start_q.size();
    int ferr = frame_err;
    push_seq(msg);
    wait_frames(base + exp.size(), exp.size() * FRAME + 50);
    wait_idle(100);
    checks++;
    if (rx_q.size() != base + exp.size()) begin
      errors++;
      $display("FAIL hello_count got %0d required %0d", rx_q.size() - base, exp.size());
    end
    foreach (exp[i]) begin
      if (base + i < rx_q.size()) begin
        checks++;
        if (rx_q[base + i] !== exp[i]) begin
          errors++;
          $display("FAIL hello_byte %0d got %h required %h", i, rx_q[base + i], exp[i]);
        end
      end
    end
    for (int i = 1; i < exp.size(); i++) begin
      if (sbase + i < start_q.size()) begin
        checks++;
        if (start_q[sbase + i] - start_q[sbase + i - 1] != FRAME) begin
          errors++;
          $display("FAIL hello_gap %0d got %0d required %0d", i,
                   start_q[sbase + i] - start_q[sbase + i - 1], FRAME);
        end
      end
    end
    checks++; if (frame_err != ferr) begin errors++; $display("FAIL hello_framing got %0d required %0d", frame_err, ferr); end
  endtask

  task automatic test_overflow;
    byte_q_t acc;
    byte_q_t exp;
    logic [7:0] b;
    int base = rx_q.size();
    int bud;
    b = 8'($urandom_range(0, 255));
    acc.push_back(b);
    push_seq(acc);
    bud = 200;
    while (!(in_frame && pos >= 8) && bud > 0) begin @(negedge clk); #1; bud--; end
    checks++;
    if (!(in_frame && pos >= 8)) begin errors++; $display("FAIL ovf_inflight frame_active=%b required 1", in_frame); end
    for (int i = 0; i < DEPTH + 2; i++) begin
      b = 8'($urandom_range(0, 255));
      char_valid = 1'b1;
      char_data  = b;
      if (i < DEPTH) acc.push_back(b);
      @(negedge clk); #1;
      checks++;
      if (char_ready !== (i + 1 < DEPTH)) begin
        errors++;
        $display("FAIL ovf_ready push %0d got %b required %b", i, char_ready, (i + 1 < DEPTH));
      end
      checks++;
      if (overflow !== (i >= DEPTH)) begin
        errors++;
        $display("FAIL ovf_flag push %0d got %b required %b", i, overflow, (i >= DEPTH));
      end
    end
    char_valid = 1'b0;
    exp = expand(acc);
    wait_frames(base + exp.size(), exp.size() * FRAME + 100);
    wait_idle(200);
    repeat (FRAME) @(negedge clk);
    #1;
    checks++;
    if (rx_q.size() != base + exp.size()) begin
      errors++;
      $display("FAIL ovf_frames got %0d required %0d", rx_q.size() - base, exp.size());
    end
    foreach (exp[i]) begin
      if (base + i < rx_q.size()) begin
        checks++;
        if (rx_q[base + i] !== exp[i]) begin
          errors++;
          $display("FAIL ovf_byte %0d got %h required %h", i, rx_q[base + i], exp[i]);
        end
      end
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b required 1", overflow); end
  endtask

  task automatic test_crlf;
    byte_q_t msg = '{8'h41, 8'h0A};
    byte_q_t exp = expand(msg);
    int base = rx_q.size();
    push_seq(msg);
    wait_frames(base + exp.size(), exp.size() * FRAME + 50);
    wait_idle(100);
    checks++;
    if (rx_q.size() != base + exp.size()) begin
      errors++;
      $display("FAIL crlf_count got %0d required %0d", rx_q.size() - base, exp.size());
    end
    foreach (exp[i]) begin
      if (base + i < rx_q.size()) begin
        checks++;
        if (rx_q[base + i] !== exp[i]) begin
          errors++;
          $display("FAIL crlf_byte %0d got %h required %h", i, rx_q[base + i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_random;
    byte_q_t sent;
    byte_q_t exp;
    int base = rx_q.size();
    int ferr = frame_err;
    int bud = 20000;
    while (sent.size() < 40 && bud > 0) begin
      @(negedge clk); #1;
      bud--;
      if (char_ready === 1'b1 && ($urandom % 3) != 0) begin
        char_valid = 1'b1;
        char_data  = 8'($urandom_range(0, 255));
        sent.push_back(char_data);
      end else begin
        char_valid = 1'b0;
      end
    end
    @(negedge clk); #1;
    char_valid = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rand_overflow got %b required 0", overflow); end
    exp = expand(sent);
    wait_frames(base + exp.size(), exp.size() * FRAME + 200);
    wait_idle(200);
    checks++;
    if (rx_q.size() != base + exp.size()) begin
      errors++;
      $display("FAIL rand_count got %0d required %0d", rx_q.size() - base, exp.size());
    end
    foreach (exp[i]) begin
      if (base + i < rx_q.size()) begin
        checks++;
        if (rx_q[base + i] !== exp[i]) begin
          errors++;
          $display("FAIL rand_byte %0d got %h required %h", i, rx_q[base + i], exp[i]);
        end
      end
    end
    checks++; if (frame_err != ferr) begin errors++; $display("FAIL rand_framing got %0d required %0d", frame_err, ferr); end
  endtask

  task automatic test_reset_mid_frame;
    byte_q_t msg;
    int bud = 200;
    int rbase;
    int sbase;
    for (int i = 0; i < 3; i++) msg.push_back(8'($urandom_range(0, 255)));
    push_seq(msg);
    while (!(in_frame && pos == 17) && bud > 0) begin @(negedge clk); #1; bud--; end
    checks++;
    if (!(in_frame && pos == 17)) begin errors++; $display("FAIL rstmid_reach frame_active=%b required 1", in_frame); end
    rst = 1'b1;
    @(negedge clk); #1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rstmid_tx got %b required 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b required 0", busy); end
    checks++; if (char_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b required 1", char_ready); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rstmid_overflow got %b required 0", overflow); end
    rst = 1'b0;
    rbase = rx_q.size();
    sbase = start_q.size();
    repeat (100) @(negedge clk);
    #1;
    checks++;
    if (start_q.size() != sbase || rx_q.size() != rbase) begin
      errors++;
      $display("FAIL rstmid_quiet got %0d frames required 0", start_q.size() - sbase);
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy_after got %b required 0", busy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_crlf();
    test_overflow();
    test_reset_mid_frame();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_term_tx
